// File: rtl/strobe_loader_seq.sv
// strobe_loader_seq: ORs ones into word-sized fields of a grouped strobe vector.
// Each word is loaded either by a single request or by a counted burst from a base index.
// Each group of STROBES_PER_GROUP bits is split into WPG words of DATA_SIZE bits.
// The last word of a group is narrower when the group width is not a multiple of DATA_SIZE.
// Optional macro STROBE_LOADER_RANGE_CHECK_EN makes ERROR a sticky flag for out-of-range word loads.
// Without that macro ERROR is tied low, and out-of-range words still load nothing.
module strobe_loader_seq #(
  parameter int ADDRESS_SIZE      = 10,
  parameter int DATA_SIZE         = 8,
  parameter int NB_GROUPS         = 3,
  parameter int STROBES_PER_GROUP = 17
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   ENABLE,
  input  logic [ADDRESS_SIZE-1:0]                ADDRESS,
  input  logic                                   BURST_START,
  input  logic [ADDRESS_SIZE-1:0]                BURST_LEN,
  input  logic                                   CLEAR,
  output logic                                   BUSY,
  output logic                                   DONE,
  output logic                                   ERROR,
  output logic [NB_GROUPS*STROBES_PER_GROUP-1:0] STROBE_OUT
);

  localparam int WPG         = (STROBES_PER_GROUP + DATA_SIZE - 1) / DATA_SIZE;
  localparam int REM         = STROBES_PER_GROUP % DATA_SIZE;
  localparam int TOTAL_WORDS = NB_GROUPS * WPG;
  localparam int W           = NB_GROUPS * STROBES_PER_GROUP;
  localparam int AW          = ADDRESS_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [AW-1:0]           addr_reg;
  logic [ADDRESS_SIZE-1:0] count_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [W-1:0]            strobe_reg;

  logic                    load_valid;
  logic [AW-1:0]           load_word;
  logic [W-1:0]            set_mask;
  logic [W-1:0]            word_mask [TOTAL_WORDS];

  // Contiguous run of ones of the given width starting at the given bit.
  function automatic logic [W-1:0] field_mask(input int base, input int width);
    logic [W-1:0] m;
    m = '0;
    for (int b = 0; b < W; b++) begin
      if (b >= base && b < base + width) m[b] = 1'b1;
    end
    return m;
  endfunction

  // One constant field per in-range word; the last slot of a group may be narrower.
  for (genvar gi = 0; gi < TOTAL_WORDS; gi++) begin : g_word
    localparam int GRP   = gi / WPG;
    localparam int SLOT  = gi % WPG;
    localparam int BASE  = GRP * STROBES_PER_GROUP + SLOT * DATA_SIZE;
    localparam int WIDTH = (SLOT == WPG - 1 && REM != 0) ? REM : DATA_SIZE;
    assign word_mask[gi] = field_mask(BASE, WIDTH);
  end

  // Select which word (if any) is loaded this cycle: single load in IDLE, burst word in BURST.
  always_comb begin
    load_valid = 1'b0;
    load_word  = '0;
    case (state_reg)
      IDLE: begin
        load_valid = ENABLE && !BURST_START;
        load_word  = {1'b0, ADDRESS};
      end
      BURST: begin
        load_valid = 1'b1;
        load_word  = addr_reg;
      end
      default: begin
        load_valid = 1'b0;
        load_word  = '0;
      end
    endcase
  end

  // Decode the selected word into its field; indices past the last word match nothing.
  always_comb begin
    set_mask = '0;
    for (int w = 0; w < TOTAL_WORDS; w++) begin
      if (load_valid && load_word == AW'(w)) set_mask = set_mask | word_mask[w];
    end
  end

  // Control FSM: IDLE accepts requests, BURST walks base..base+count-1, FIN pulses DONE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (BURST_START) begin
            if (BURST_LEN != '0) begin
              addr_reg  <= {1'b0, ADDRESS};
              count_reg <= BURST_LEN;
              busy_reg  <= 1'b1;
              state_reg <= BURST;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end
          end
        end
        BURST: begin
          if (CLEAR) begin
            // Abort: back to IDLE without a completion pulse.
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            addr_reg  <= addr_reg + AW'(1);
            count_reg <= count_reg - ADDRESS_SIZE'(1);
            if (count_reg == ADDRESS_SIZE'(1)) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Strobe vector: CLEAR wins over any load, otherwise accumulate the selected field.
  always_ff @(posedge CLK) begin
    if (RESET || CLEAR) begin
      strobe_reg <= '0;
    end else begin
      strobe_reg <= strobe_reg | set_mask;
    end
  end

`ifdef STROBE_LOADER_RANGE_CHECK_EN
  logic error_reg;
  logic out_of_range;

  assign out_of_range = load_valid && (load_word >= AW'(TOTAL_WORDS));

  // Sticky out-of-range flag, cleared only by CLEAR or RESET.
  always_ff @(posedge CLK) begin
    if (RESET || CLEAR) begin
      error_reg <= 1'b0;
    end else if (out_of_range) begin
      error_reg <= 1'b1;
    end
  end

  assign ERROR = error_reg;
`else
  assign ERROR = 1'b0;
`endif

  assign BUSY       = busy_reg;
  assign DONE       = done_reg;
  assign STROBE_OUT = strobe_reg;

endmodule

// File: tb/tb_strobe_loader_seq.sv
// Directed bench for strobe_loader_seq at default parameters (WPG=3, REM=1, 9 words, 51 bits).
module tb_strobe_loader_seq;

  logic        CLK;
  logic        RESET;
  logic        ENABLE;
  logic [9:0]  ADDRESS;
  logic        BURST_START;
  logic [9:0]  BURST_LEN;
  logic        CLEAR;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [50:0] STROBE_OUT;

  int checks;
  int errors;

`ifdef STROBE_LOADER_RANGE_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  strobe_loader_seq dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .ADDRESS    (ADDRESS),
    .BURST_START(BURST_START),
    .BURST_LEN  (BURST_LEN),
    .CLEAR      (CLEAR),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .STROBE_OUT (STROBE_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock edge and settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    RESET = 1'b0; ENABLE = 1'b0; ADDRESS = '0;
    BURST_START = 1'b0; BURST_LEN = '0; CLEAR = 1'b0;
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    checks++;
    if (STROBE_OUT !== 51'h0 || BUSY !== 1'b0 || DONE !== 1'b0 || ERROR !== 1'b0) begin
      errors++;
      $display("FAIL reset: strobe=%h busy=%b done=%b error=%b, required all 0", STROBE_OUT, BUSY, DONE, ERROR);
    end
    $display("reset: strobe=%h busy=%b done=%b error=%b", STROBE_OUT, BUSY, DONE, ERROR);
  endtask

  task automatic test_single_load();
    logic [50:0] exp;
    ENABLE = 1'b1; ADDRESS = 10'd2;
    tick();
    exp = 51'h1 << 16;
    checks++;
    if (STROBE_OUT !== exp) begin
      errors++;
      $display("FAIL single_addr2: strobe=%h required %h", STROBE_OUT, exp);
    end
    $display("single addr=2: strobe=%h", STROBE_OUT);
    ADDRESS = 10'd3;
    tick();
    ENABLE = 1'b0;
    exp = 51'h1FF << 16;
    checks++;
    if (STROBE_OUT !== exp || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL single_addr3: strobe=%h busy=%b required %h busy=0", STROBE_OUT, BUSY, exp);
    end
    $display("single addr=3: strobe=%h", STROBE_OUT);
    do_clear();
    checks++;
    if (STROBE_OUT !== 51'h0) begin
      errors++;
      $display("FAIL clear_idle: strobe=%h required 0", STROBE_OUT);
    end
    $display("clear: strobe=%h", STROBE_OUT);
  endtask

  task automatic test_out_of_range_single();
    ENABLE = 1'b1; ADDRESS = 10'd9;
    tick();
    ADDRESS = 10'd1023;
    tick();
    ENABLE = 1'b0;
    checks++;
    if (STROBE_OUT !== 51'h0 || ERROR !== ERR_EXP) begin
      errors++;
      $display("FAIL oor_single: strobe=%h error=%b required 0 error=%b", STROBE_OUT, ERROR, ERR_EXP);
    end
    $display("single addr=9,1023: strobe=%h error=%b", STROBE_OUT, ERROR);
    do_clear();
    checks++;
    if (ERROR !== 1'b0) begin
      errors++;
      $display("FAIL oor_clear: error=%b required 0", ERROR);
    end
  endtask

  task automatic test_full_burst();
    int busy_cycles;
    BURST_START = 1'b1; ADDRESS = 10'd0; BURST_LEN = 10'd9;
    tick();
    BURST_START = 1'b0; BURST_LEN = '0;
    busy_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      if (BUSY === 1'b1 && DONE === 1'b0) busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != 9) begin
      errors++;
      $display("FAIL full_busy: busy cycles=%0d required 9", busy_cycles);
    end
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || STROBE_OUT !== {51{1'b1}}) begin
      errors++;
      $display("FAIL full_done: done=%b busy=%b strobe=%h required done=1 busy=0 all ones", DONE, BUSY, STROBE_OUT);
    end
    $display("full burst: busy_cycles=%0d done=%b strobe=%h", busy_cycles, DONE, STROBE_OUT);
    tick();
    checks++;
    if (DONE !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse: done=%b required 0", DONE);
    end
    do_clear();
  endtask

  task automatic test_range_burst();
    int busy_cycles;
    logic [50:0] exp;
    exp = 51'h1FF << 42;
    BURST_START = 1'b1; ADDRESS = 10'd7; BURST_LEN = 10'd4;
    tick();
    BURST_START = 1'b0; BURST_LEN = '0; ADDRESS = '0;
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (BUSY === 1'b1 && DONE === 1'b0) busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != 4) begin
      errors++;
      $display("FAIL range_busy: busy cycles=%0d required 4", busy_cycles);
    end
    checks++;
    if (DONE !== 1'b1 || STROBE_OUT !== exp || ERROR !== ERR_EXP) begin
      errors++;
      $display("FAIL range_done: done=%b strobe=%h error=%b required done=1 %h error=%b", DONE, STROBE_OUT, ERROR, exp, ERR_EXP);
    end
    $display("range burst: busy_cycles=%0d done=%b strobe=%h error=%b", busy_cycles, DONE, STROBE_OUT, ERROR);
    tick();
    tick();
    checks++;
    if (DONE !== 1'b0 || ERROR !== ERR_EXP) begin
      errors++;
      $display("FAIL range_after: done=%b error=%b required done=0 error=%b", DONE, ERROR, ERR_EXP);
    end
    do_clear();
  endtask

  task automatic test_clear_abort();
    int done_seen;
    BURST_START = 1'b1; ADDRESS = 10'd0; BURST_LEN = 10'd5;
    tick();
    BURST_START = 1'b0; BURST_LEN = '0;
    tick();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    checks++;
    if (STROBE_OUT !== 51'h0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: strobe=%h busy=%b done=%b required 0/0/0", STROBE_OUT, BUSY, DONE);
    end
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DONE !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0 || STROBE_OUT !== 51'h0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: done_seen=%0d strobe=%h busy=%b required 0/0/0", done_seen, STROBE_OUT, BUSY);
    end
    $display("clear abort: strobe=%h busy=%b done_seen=%0d", STROBE_OUT, BUSY, done_seen);
  endtask

  task automatic test_zero_len();
    BURST_START = 1'b1; ENABLE = 1'b1; ADDRESS = 10'd1; BURST_LEN = 10'd0;
    tick();
    BURST_START = 1'b0; ENABLE = 1'b0; ADDRESS = '0;
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || STROBE_OUT !== 51'h0) begin
      errors++;
      $display("FAIL zero_len: done=%b busy=%b strobe=%h required done=1 busy=0 strobe=0", DONE, BUSY, STROBE_OUT);
    end
    $display("zero len: done=%b strobe=%h", DONE, STROBE_OUT);
    tick();
    checks++;
    if (DONE !== 1'b0 || STROBE_OUT !== 51'h0) begin
      errors++;
      $display("FAIL zero_len_after: done=%b strobe=%h required 0/0", DONE, STROBE_OUT);
    end
  endtask

  task automatic test_reset_mid_burst();
    BURST_START = 1'b1; ADDRESS = 10'd0; BURST_LEN = 10'd9;
    tick();
    BURST_START = 1'b0; BURST_LEN = '0;
    tick();
    tick();
    checks++;
    if (STROBE_OUT !== 51'hFFFF || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL mid_burst: strobe=%h busy=%b required ffff busy=1", STROBE_OUT, BUSY);
    end
    RESET = 1'b1; CLEAR = 1'b1; ENABLE = 1'b1; ADDRESS = 10'd4;
    tick();
    RESET = 1'b0; CLEAR = 1'b0; ENABLE = 1'b0;
    checks++;
    if (STROBE_OUT !== 51'h0 || BUSY !== 1'b0 || DONE !== 1'b0 || ERROR !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: strobe=%h busy=%b done=%b error=%b required all 0", STROBE_OUT, BUSY, DONE, ERROR);
    end
    ENABLE = 1'b1; ADDRESS = 10'd8;
    tick();
    ENABLE = 1'b0;
    tick();
    tick();
    checks++;
    if (STROBE_OUT !== (51'h1 << 50) || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_addr8: strobe=%h busy=%b done=%b required %h busy=0 done=0", STROBE_OUT, BUSY, DONE, 51'h1 << 50);
    end
    $display("reset mid burst then addr=8: strobe=%h", STROBE_OUT);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_load();
    test_out_of_range_single();
    test_full_burst();
    test_range_burst();
    test_clear_abort();
    test_zero_len();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
